multicycle_processor: RTL and testbench

Parametrised multi-cycle successor to the team's single-cycle processor. It executes an RV32I subset: add, sub, and, or, slt, addi, lw, sw, beq, jal and ebreak. It uses a fetch/decode/execute/memory/writeback FSM and talks to external instruction and data memories over req/ready handshakes, so slow memories stall the core. Debug outputs match the single-cycle core (instr, pc_out, imm_out, alu_control, alu_result), plus FSM state and halt status.

---
 rtl/multicycle_processor.sv | 266 ++++++++++++++++++++++++++
 tb/tb_multicycle_processor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_processor.sv
// Multi-cycle RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq/jal/ebreak) with req/ready memories.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_processor #(
    parameter int unsigned         XLEN     = 32,
    parameter int unsigned         PC_WIDTH = 10,
    parameter int unsigned         NUM_REGS = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ready,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_ready,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [20:0]         imm_out,
    output logic [2:0]          alu_control,
    output logic [XLEN-1:0]     alu_result,
    output logic [2:0]          state,
    output logic                halted
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         retired_cnt
`endif
);

    localparam int unsigned RIDX = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [20:0]         imm_q, imm_d;
    logic [2:0]          alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0]     alu_result_q, alu_result_d;
    logic [XLEN-1:0]     load_q, load_d;
    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RIDX-1:0] rd_idx, rs1_idx, rs2_idx;
    logic            is_r, is_addi, is_lw, is_sw, is_beq, is_jal, legal;
    logic [20:0]     imm_dec;
    logic [2:0]      alu_ctrl_dec;
    logic [XLEN-1:0] imm_x, rs1_val, rs2_val, alu_b, alu_out;
    logic [PC_WIDTH-1:0] pc_plus4, pc_target;

    // Register fields are narrowed to RIDX bits, so a 16-entry file ignores index bit 4.
    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];
    assign rd_idx  = instr_q[7 +: RIDX];
    assign rs1_idx = instr_q[15 +: RIDX];
    assign rs2_idx = instr_q[20 +: RIDX];

    always_comb begin
        is_r = 1'b0;
        if (opcode == OP_R) begin
            if (funct7 == 7'b0000000)
                is_r = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                       (funct3 == 3'b110) || (funct3 == 3'b010);
            else if (funct7 == 7'b0100000)
                is_r = (funct3 == 3'b000);
        end
    end

    assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
    assign is_lw   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    assign is_sw   = (opcode == OP_STORE)  && (funct3 == 3'b010);
    assign is_beq  = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign is_jal  = (opcode == OP_JAL);
    assign legal   = is_r || is_addi || is_lw || is_sw || is_beq || is_jal;

    always_comb begin
        imm_dec = '0;
        case (opcode)
            OP_IMM, OP_LOAD: imm_dec = {{9{instr_q[31]}}, instr_q[31:20]};
            OP_STORE:        imm_dec = {{9{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BRANCH:       imm_dec = {{8{instr_q[31]}}, instr_q[31], instr_q[7],
                                        instr_q[30:25], instr_q[11:8], 1'b0};
            OP_JAL:          imm_dec = {instr_q[31], instr_q[19:12], instr_q[20],
                                        instr_q[30:21], 1'b0};
            default:         imm_dec = '0;
        endcase
    end

    always_comb begin
        alu_ctrl_dec = ALU_ADD;
        if (is_beq) begin
            alu_ctrl_dec = ALU_SUB;
        end else if (is_r) begin
            case (funct3)
                3'b000:  alu_ctrl_dec = funct7[5] ? ALU_SUB : ALU_ADD;
                3'b111:  alu_ctrl_dec = ALU_AND;
                3'b110:  alu_ctrl_dec = ALU_OR;
                3'b010:  alu_ctrl_dec = ALU_SLT;
                default: alu_ctrl_dec = ALU_ADD;
            endcase
        end
    end

    assign imm_x   = {{(XLEN-21){imm_q[20]}}, imm_q};
    assign rs1_val = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
    assign alu_b   = (is_r || is_beq) ? rs2_val : imm_x;

    always_comb begin
        alu_out = '0;
        case (alu_ctrl_q)
            ALU_ADD: alu_out = rs1_val + alu_b;
            ALU_SUB: alu_out = rs1_val - alu_b;
            ALU_AND: alu_out = rs1_val & alu_b;
            ALU_OR:  alu_out = rs1_val | alu_b;
            ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(alu_b))};
            default: alu_out = '0;
        endcase
    end

    assign pc_plus4  = pc_q + PC_WIDTH'(4);
    assign pc_target = pc_q + imm_x[PC_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_result_d = alu_result_q;
        load_d       = load_q;
        regs_d       = regs_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_HALT;
                end else begin
                    imm_d      = imm_dec;
                    alu_ctrl_d = alu_ctrl_dec;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_result_d = alu_out;
                state_d      = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_lw)
                        load_d = dmem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (rd_idx != '0) begin
                    if (is_r || is_addi)
                        regs_d[rd_idx] = alu_result_q;
                    else if (is_lw)
                        regs_d[rd_idx] = load_q;
                    else if (is_jal)
                        regs_d[rd_idx] = XLEN'(pc_plus4);
                end
                // beq reuses the SUB result: zero means the operands were equal.
                pc_d    = (is_jal || (is_beq && (alu_result_q == '0))) ? pc_target : pc_plus4;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            imm_q        <= '0;
            alu_ctrl_q   <= '0;
            alu_result_q <= '0;
            load_q       <= '0;
            regs_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            imm_q        <= imm_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_result_q <= alu_result_d;
            load_q       <= load_d;
            regs_q       <= regs_d;
        end
    end

    // Requests are gated by reset so an abandoned transaction drops without waiting for a clock.
    assign imem_req    = reset && (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign dmem_req    = reset && (state_q == S_MEM);
    assign dmem_we     = is_sw;
    assign dmem_addr   = alu_result_q;
    assign dmem_wdata  = rs2_val;
    assign instr       = instr_q;
    assign pc_out      = pc_q;
    assign imm_out     = imm_q;
    assign alu_control = alu_ctrl_q;
    assign alu_result  = alu_result_q;
    assign state       = state_q;
    assign halted      = (state_q == S_HALT);

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        retired_cnt_d = (state_q == S_WB) ? retired_cnt_q + 32'd1 : retired_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor with behavioural instruction/data memories.
// Counter checks are compiled in when PERF_CNT_EN is defined.
module tb_multicycle_processor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] instr;
    logic [9:0]  pc_out;
    logic [20:0] imm_out;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic [2:0]  state;
    logic        halted;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic        imem_ready_en = 1'b1;
    int unsigned dmem_lat = 0;
    int unsigned dcnt = 0;
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    multicycle_processor #(.XLEN(32), .PC_WIDTH(10), .NUM_REGS(32), .RESET_PC(10'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ready  (dmem_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .imm_out     (imm_out),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .state       (state),
        .halted      (halted)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign imem_ready = imem_ready_en;
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_ready = dmem_req && (dcnt >= dmem_lat);
    assign dmem_rdata = dmem[dmem_addr[9:2]];

    always @(posedge clk) begin
        if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
        else                         dcnt <= 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
    end

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [2:0]  exp_ctl [5];
    logic [31:0] exp_res [5];

    initial begin
        // Reset values and back-to-back addi
        clear_mem();
        imem[0] = addi(5'd1, 5'd0, 12'd5);
        imem[1] = addi(5'd2, 5'd1, 12'hFFD);
        #2 reset = 1'b0;
        #10;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", {22'd0, pc_out}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_imm", {11'd0, imm_out}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1);
        chk("t1_decode_state", {29'd0, state}, 32'd1);
        chk("t1_instr", instr, 32'h00500093);
        step(3);
        chk("t1_x1", dut.regs_q[1], 32'd5);
        chk("t1_pc4", {22'd0, pc_out}, 32'd4);
        step(2);
        chk("t1_exec_state", {29'd0, state}, 32'd2);
        chk("t1_imm_neg3", {11'd0, imm_out}, 32'h001FFFFD);
        step(2);
        chk("t1_x2", dut.regs_q[2], 32'd2);
        chk("t1_pc8", {22'd0, pc_out}, 32'd8);

        // R-type ALU ops on x1=7, x2=-2
        clear_mem();
        imem[0] = addi(5'd1, 5'd0, 12'd7);
        imem[1] = addi(5'd2, 5'd0, 12'hFFE);
        imem[2] = rtype(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
        imem[3] = rtype(7'h20, 3'b000, 5'd4, 5'd1, 5'd2);
        imem[4] = rtype(7'h00, 3'b111, 5'd5, 5'd1, 5'd2);
        imem[5] = rtype(7'h00, 3'b110, 5'd6, 5'd1, 5'd2);
        imem[6] = rtype(7'h00, 3'b010, 5'd7, 5'd2, 5'd1);
        exp_ctl = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        exp_res = '{32'd5, 32'd9, 32'd6, 32'hFFFFFFFF, 32'd1};
        do_reset();
        step(8);
        for (int k = 0; k < 5; k++) begin
            step(2);
            chk($sformatf("t2_ctl%0d", k), {29'd0, alu_control}, {29'd0, exp_ctl[k]});
            step(1);
            chk($sformatf("t2_res%0d", k), alu_result, exp_res[k]);
            step(1);
            chk($sformatf("t2_reg%0d", k + 3), dut.regs_q[k + 3], exp_res[k]);
        end

        // Store then load with a slow data memory
        clear_mem();
        dmem_lat = 3;
        imem[0] = addi(5'd1, 5'd0, 12'd7);
        imem[1] = sw(5'd1, 5'd0, 12'd16);
        imem[2] = lw(5'd3, 5'd0, 12'd16);
        do_reset();
        step(7);
        chk("t3_mem_state", {29'd0, state}, 32'd3);
        chk("t3_req0", {31'd0, dmem_req}, 32'd1);
        chk("t3_we", {31'd0, dmem_we}, 32'd1);
        chk("t3_addr0", dmem_addr, 32'd16);
        chk("t3_wdata", dmem_wdata, 32'd7);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk($sformatf("t3_req%0d", i), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("t3_addr%0d", i), dmem_addr, 32'd16);
        end
        step(1);
        chk("t3_wb_state", {29'd0, state}, 32'd4);
        chk("t3_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("t3_stored", dmem[4], 32'd7);
        step(1);
        chk("t3_pc_sw", {22'd0, pc_out}, 32'd8);
        step(8);
        chk("t3_pc_lw", {22'd0, pc_out}, 32'd12);
        chk("t3_x3", dut.regs_q[3], 32'd7);

        // beq taken and not taken
        clear_mem();
        dmem_lat = 0;
        imem[0] = addi(5'd1, 5'd0, 12'd3);
        imem[1] = addi(5'd2, 5'd0, 12'd3);
        imem[2] = beq(5'd1, 5'd2, 13'd8);
        imem[3] = addi(5'd5, 5'd0, 12'd1);
        imem[4] = beq(5'd1, 5'd0, 13'd8);
        imem[5] = addi(5'd6, 5'd0, 12'd9);
        do_reset();
        step(12);
        chk("t4_beq_taken_pc", {22'd0, pc_out}, 32'd16);
        step(4);
        chk("t4_beq_not_taken_pc", {22'd0, pc_out}, 32'd20);
        step(4);
        chk("t4_x6", dut.regs_q[6], 32'd9);
        chk("t4_x5_skipped", dut.regs_q[5], 32'd0);

        // jal backwards from PC 0 wraps, with a stalled fetch first
        clear_mem();
        imem[0] = jal(5'd1, 21'h1FFFFC);
        imem_ready_en = 1'b0;
        do_reset();
        step(2);
        chk("t5_stall_state", {29'd0, state}, 32'd0);
        chk("t5_stall_req", {31'd0, imem_req}, 32'd1);
        imem_ready_en = 1'b1;
        step(1);
        chk("t5_decode", {29'd0, state}, 32'd1);
        step(1);
        chk("t5_jal_imm", {11'd0, imm_out}, 32'h001FFFFC);
        step(2);
        chk("t5_pc_wrap", {22'd0, pc_out}, 32'h3FC);
        chk("t5_x1_link", dut.regs_q[1], 32'd4);

        // Unsupported opcode halts
        clear_mem();
        imem[0] = 32'h0000007F;
        do_reset();
        step(1);
        chk("t6_decode", {29'd0, state}, 32'd1);
        step(1);
        chk("t6_halt_state", {29'd0, state}, 32'd5);
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_no_req", {31'd0, imem_req}, 32'd0);
        step(5);
        chk("t6_still_halt", {29'd0, state}, 32'd5);
        chk("t6_still_no_req", {31'd0, imem_req}, 32'd0);
        chk("t6_pc_frozen", {22'd0, pc_out}, 32'd0);

        // ebreak halts after retiring the preceding instruction
        clear_mem();
        imem[0] = addi(5'd1, 5'd0, 12'd1);
        imem[1] = 32'h00100073;
        imem[2] = addi(5'd1, 5'd0, 12'd2);
        do_reset();
        step(6);
        chk("t6_ebreak_halt", {29'd0, state}, 32'd5);
        step(4);
        chk("t6_ebreak_x1", dut.regs_q[1], 32'd1);
        chk("t6_ebreak_pc", {22'd0, pc_out}, 32'd4);

        // Asynchronous reset during a stalled store
        clear_mem();
        dmem_lat = 10;
        imem[0] = addi(5'd1, 5'd0, 12'd7);
        imem[1] = sw(5'd1, 5'd0, 12'd16);
        do_reset();
        step(7);
        chk("t7_in_mem", {31'd0, dmem_req}, 32'd1);
        chk("t7_pc_before", {22'd0, pc_out}, 32'd4);
        #2 reset = 1'b0;
        #1;
        chk("t7_req_dropped", {31'd0, dmem_req}, 32'd0);
        chk("t7_pc_reset", {22'd0, pc_out}, 32'd0);
        chk("t7_state_reset", {29'd0, state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dmem_lat = 0;

`ifdef PERF_CNT_EN
        // Counters over three addi then ebreak
        clear_mem();
        imem[0] = addi(5'd1, 5'd0, 12'd1);
        imem[1] = addi(5'd2, 5'd0, 12'd2);
        imem[2] = addi(5'd3, 5'd0, 12'd3);
        imem[3] = 32'h00100073;
        do_reset();
        step(14);
        chk("t8_halt", {29'd0, state}, 32'd5);
        chk("t8_cycle_cnt", cycle_cnt, 32'd14);
        chk("t8_retired_cnt", retired_cnt, 32'd3);
        step(6);
        chk("t8_cycle_frozen", cycle_cnt, 32'd14);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
